// File: rtl/div_pkg.sv
// Shared types and default sizing for the clock-divider run controller.
package div_pkg;

    localparam int CNT_W_DFLT    = 24;
    localparam int DEF_HALF_DFLT = 12_500_000;
    localparam int BURST_W_DFLT  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/div_core.sv
// Half-period counter and square-wave generator; strobes the phase edges to
// the controller one cycle before they become visible on clk_o.
module div_core #(
    parameter int CNT_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] half_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             rise_o,
    output logic             fall_o
);

    logic [CNT_W-1:0] cnt;
    logic             at_end;

    // The strobes announce the toggle that the coming edge will perform.
    assign at_end = en_i && (cnt == half_i);
    assign rise_o = at_end && !clk_o;
    assign fall_o = at_end && clk_o;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt    <= CNT_W'(1);
            clk_o  <= 1'b0;
            tick_o <= 1'b0;
        end else if (restart_i) begin
            cnt    <= CNT_W'(1);
            clk_o  <= 1'b0;
            tick_o <= 1'b0;
        end else if (at_end) begin
            cnt    <= CNT_W'(1);
            clk_o  <= !clk_o;
            tick_o <= !clk_o;
        end else begin
            tick_o <= 1'b0;
            if (en_i) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Run controller: start/stop/burst FSM, burst counter and the half-period
// shadow register that is swapped in only at a rising toggle or on return to IDLE.
module div_ctrl
    import div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DFLT,
    parameter int DEF_HALF = DEF_HALF_DFLT,
    parameter int BURST_W  = BURST_W_DFLT
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [BURST_W-1:0] burst_len_i,
    input  logic               cfg_valid_i,
    input  logic [CNT_W-1:0]   cfg_half_i,
    output logic               cfg_ready_o,
    output logic               clk_o,
    output logic               tick_o,
    output logic               busy_o,
    output logic               done_o
);

    state_e             state, state_nxt;
    logic [BURST_W-1:0] bcnt;
    logic [CNT_W-1:0]   active_half;
    logic [CNT_W-1:0]   pend_half;
    logic               pend;
    logic               done_q;

    logic               rise, fall;
    logic               start_acc, going_idle;
    logic               core_en, core_restart;
    logic               cfg_xfer;
    logic [CNT_W-1:0]   cfg_val;

    assign cfg_ready_o = !pend;
    assign cfg_xfer    = cfg_valid_i && !pend;
    assign cfg_val     = (cfg_half_i == '0) ? CNT_W'(1) : cfg_half_i;
    assign busy_o      = (state != IDLE);
    assign done_o      = done_q;

    div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (core_en),
        .restart_i (core_restart),
        .half_i    (active_half),
        .clk_o     (clk_o),
        .tick_o    (tick_o),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        start_acc    = 1'b0;
        going_idle   = 1'b0;
        core_en      = 1'b0;
        core_restart = 1'b0;

        case (state)
            IDLE: begin
                if (start_i && !stop_i) begin
                    state_nxt = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                core_en = 1'b1;
                if (fall && (bcnt == BURST_W'(1))) begin
                    state_nxt = IDLE;
                end else if (stop_i) begin
                    // A high phase already on the pin is finished, never cut short.
                    state_nxt = (clk_o && !fall) ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                core_en = 1'b1;
                if (fall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        going_idle   = (state != IDLE) && (state_nxt == IDLE);
        core_restart = (state == IDLE) || (state_nxt == IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= going_idle;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bcnt <= '0;
        end else if (start_acc) begin
            bcnt <= burst_len_i;
        end else if ((state == RUN) && fall && (bcnt != '0)) begin
            bcnt <= bcnt - BURST_W'(1);
        end
    end

    // Config shadow: direct write when idle, otherwise staged until a safe boundary.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            active_half <= CNT_W'(DEF_HALF);
            pend_half   <= '0;
            pend        <= 1'b0;
        end else if (state == IDLE) begin
            if (cfg_xfer) begin
                active_half <= cfg_val;
            end
        end else if (going_idle) begin
            if (pend) begin
                active_half <= pend_half;
                pend        <= 1'b0;
            end else if (cfg_xfer) begin
                active_half <= cfg_val;
            end
        end else if (rise && pend) begin
            active_half <= pend_half;
            pend        <= 1'b0;
        end else if (cfg_xfer) begin
            pend_half <= cfg_val;
            pend      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed waveform scenarios plus a
// randomized run compared against an event-time reference model.
module tb_div_ctrl;

    localparam int CNT_W    = 24;
    localparam int DEF_HALF = 7;
    localparam int BURST_W  = 8;

    logic               clk_i = 1'b0;
    logic               rst_n_i = 1'b0;
    logic               start_i = 1'b0;
    logic               stop_i = 1'b0;
    logic [BURST_W-1:0] burst_len_i = '0;
    logic               cfg_valid_i = 1'b0;
    logic [CNT_W-1:0]   cfg_half_i = '0;
    logic               cfg_ready_o, clk_o, tick_o, busy_o, done_o;

    int n_pass  = 0;
    int n_total = 0;

    div_ctrl #(
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF),
        .BURST_W  (BURST_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .burst_len_i (burst_len_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_half_i  (cfg_half_i),
        .cfg_ready_o (cfg_ready_o),
        .clk_o       (clk_o),
        .tick_o      (tick_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model (absolute toggle times) ----------------
    int     m_mode;          // 0 idle, 1 run, 2 drain
    bit     m_lvl, m_tick, m_done, m_pend;
    int     m_half, m_pend_half, m_bleft;
    longint m_edge, m_toggle_at;

    task automatic model_reset();
        m_mode = 0; m_lvl = 0; m_tick = 0; m_done = 0; m_pend = 0;
        m_half = DEF_HALF; m_pend_half = 0; m_bleft = 0;
        m_edge = 0; m_toggle_at = 0;
    endtask

    task automatic model_edge(input bit st, input bit sp, input int bl, input bit cv, input int ch);
        bit xfer, tog, rise, fall, to_idle;
        int chc;
        m_edge++;
        chc    = (ch == 0) ? 1 : ch;
        xfer   = cv && !m_pend;
        tog    = (m_mode != 0) && (m_edge == m_toggle_at);
        rise   = tog && !m_lvl;
        fall   = tog && m_lvl;
        m_tick = 0;
        m_done = 0;
        if (m_mode == 0) begin
            if (xfer) m_half = chc;
            if (st && !sp) begin
                m_mode      = 1;
                m_bleft     = bl;
                m_toggle_at = m_edge + m_half;
            end
        end else begin
            to_idle = (fall && (m_mode == 2 || m_bleft == 1)) ||
                      (m_mode == 1 && sp && (!m_lvl || fall));
            if (to_idle) begin
                m_mode = 0; m_lvl = 0; m_done = 1;
                if (m_pend) begin
                    m_half = m_pend_half; m_pend = 0;
                end else if (xfer) begin
                    m_half = chc;
                end
            end else begin
                if (m_mode == 1 && sp) m_mode = 2;
                if (rise && m_pend) begin
                    m_half = m_pend_half; m_pend = 0;
                end else if (xfer) begin
                    m_pend = 1; m_pend_half = chc;
                end
                if (tog) begin
                    m_lvl       = !m_lvl;
                    m_toggle_at = m_edge + m_half;
                    m_tick      = rise;
                end
                if (fall && m_bleft != 0) m_bleft--;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic st, input logic sp, input logic [BURST_W-1:0] bl,
                        input logic cv, input logic [CNT_W-1:0] ch);
        start_i = st; stop_i = sp; burst_len_i = bl; cfg_valid_i = cv; cfg_half_i = ch;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_half_idle(input logic [CNT_W-1:0] h);
        step(1'b0, 1'b0, '0, 1'b1, h);
    endtask

    task automatic go_idle();
        int n = 0;
        while (busy_o && n < 100) begin
            step(1'b0, 1'b1, '0, 1'b0, '0);
            n++;
        end
        if (busy_o) begin
            $display("FAIL go_idle: busy_o still %0b after 100 stop cycles", busy_o);
            $fatal(1);
        end
        step(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n_i = 1'b0;
        #12;
        n_total++;
        if ({clk_o, tick_o, busy_o, done_o, cfg_ready_o} !== 5'b00001)
            $display("FAIL reset_hold: got %b want 00001", {clk_o, tick_o, busy_o, done_o, cfg_ready_o});
        else n_pass++;
        #10 rst_n_i = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0, '0);
        n_total++;
        if ({clk_o, tick_o, busy_o, done_o, cfg_ready_o} !== 5'b00001)
            $display("FAIL reset_release: got %b want 00001", {clk_o, tick_o, busy_o, done_o, cfg_ready_o});
        else n_pass++;
    endtask

    task automatic test_free_run();
        logic [31:0] clk_v = '0, tick_v = '0, busy_v = '0;
        set_half_idle(24'd3);
        step(1'b1, 1'b0, 8'd0, 1'b0, '0);
        clk_v[0] = clk_o; tick_v[0] = tick_o; busy_v[0] = busy_o;
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b0, '0, 1'b0, '0);
            clk_v[k] = clk_o; tick_v[k] = tick_o; busy_v[k] = busy_o;
        end
        n_total++;
        if (clk_v !== 32'h0001_8E38) $display("FAIL free_run_clk: got %h want 00018e38", clk_v);
        else n_pass++;
        n_total++;
        if (tick_v !== 32'h0000_8208) $display("FAIL free_run_tick: got %h want 00008208", tick_v);
        else n_pass++;
        n_total++;
        if (busy_v !== 32'h0001_FFFF) $display("FAIL free_run_busy: got %h want 0001ffff", busy_v);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_burst();
        logic [31:0] clk_v = '0, tick_v = '0, busy_v = '0, done_v = '0;
        set_half_idle(24'd3);
        step(1'b1, 1'b0, 8'd2, 1'b0, '0);
        clk_v[0] = clk_o; tick_v[0] = tick_o; busy_v[0] = busy_o; done_v[0] = done_o;
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b0, '0, 1'b0, '0);
            clk_v[k] = clk_o; tick_v[k] = tick_o; busy_v[k] = busy_o; done_v[k] = done_o;
        end
        n_total++;
        if (clk_v !== 32'h0000_0E38) $display("FAIL burst_clk: got %h want 00000e38", clk_v);
        else n_pass++;
        n_total++;
        if (tick_v !== 32'h0000_0208) $display("FAIL burst_tick: got %h want 00000208", tick_v);
        else n_pass++;
        n_total++;
        if (done_v !== 32'h0000_1000) $display("FAIL burst_done: got %h want 00001000", done_v);
        else n_pass++;
        n_total++;
        if (busy_v !== 32'h0000_0FFF) $display("FAIL burst_busy: got %h want 00000fff", busy_v);
        else n_pass++;
    endtask

    task automatic test_stop();
        logic [31:0] clk_v = '0, busy_v = '0, done_v = '0;
        // Stop while high: phase completes via DRAIN.
        set_half_idle(24'd4);
        step(1'b1, 1'b0, 8'd0, 1'b0, '0);
        clk_v[0] = clk_o; busy_v[0] = busy_o; done_v[0] = done_o;
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, (k == 5), '0, 1'b0, '0);
            clk_v[k] = clk_o; busy_v[k] = busy_o; done_v[k] = done_o;
        end
        n_total++;
        if (clk_v !== 32'h0000_00F0) $display("FAIL stop_high_clk: got %h want 000000f0", clk_v);
        else n_pass++;
        n_total++;
        if (done_v !== 32'h0000_0100) $display("FAIL stop_high_done: got %h want 00000100", done_v);
        else n_pass++;
        n_total++;
        if (busy_v !== 32'h0000_00FF) $display("FAIL stop_high_busy: got %h want 000000ff", busy_v);
        else n_pass++;
        // Stop while low: immediate return, no high phase at all.
        clk_v = '0; busy_v = '0; done_v = '0;
        step(1'b1, 1'b0, 8'd0, 1'b0, '0);
        clk_v[0] = clk_o; busy_v[0] = busy_o; done_v[0] = done_o;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, (k == 3), '0, 1'b0, '0);
            clk_v[k] = clk_o; busy_v[k] = busy_o; done_v[k] = done_o;
        end
        n_total++;
        if (clk_v !== 32'h0) $display("FAIL stop_low_clk: got %h want 00000000", clk_v);
        else n_pass++;
        n_total++;
        if (done_v !== 32'h0000_0008) $display("FAIL stop_low_done: got %h want 00000008", done_v);
        else n_pass++;
        n_total++;
        if (busy_v !== 32'h0000_0007) $display("FAIL stop_low_busy: got %h want 00000007", busy_v);
        else n_pass++;
    endtask

    task automatic test_cfg_running();
        logic [31:0] clk_v = '0, rdy_v = '0;
        set_half_idle(24'd3);
        step(1'b1, 1'b0, 8'd0, 1'b0, '0);
        clk_v[0] = clk_o; rdy_v[0] = cfg_ready_o;
        for (int k = 1; k <= 20; k++) begin
            step(1'b0, 1'b0, '0, (k == 1 || k == 2), (k == 1) ? 24'd5 : 24'd9);
            clk_v[k] = clk_o; rdy_v[k] = cfg_ready_o;
        end
        n_total++;
        if (rdy_v !== 32'h001F_FFF9) $display("FAIL cfg_ready: got %h want 001ffff9", rdy_v);
        else n_pass++;
        n_total++;
        if (clk_v !== 32'h0003_E0F8) $display("FAIL cfg_phases: got %h want 0003e0f8", clk_v);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_half_zero();
        logic [31:0] clk_v = '0, tick_v = '0;
        set_half_idle(24'd0);
        step(1'b1, 1'b0, 8'd0, 1'b0, '0);
        clk_v[0] = clk_o; tick_v[0] = tick_o;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0, '0, 1'b0, '0);
            clk_v[k] = clk_o; tick_v[k] = tick_o;
        end
        n_total++;
        if (clk_v !== 32'h0000_02AA) $display("FAIL half0_clk: got %h want 000002aa", clk_v);
        else n_pass++;
        n_total++;
        if (tick_v !== 32'h0000_02AA) $display("FAIL half0_tick: got %h want 000002aa", tick_v);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] clk_v = '0, tick_v = '0;
        set_half_idle(24'd4);
        step(1'b1, 1'b0, 8'd0, 1'b0, '0);
        for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, '0, 1'b0, '0);
        n_total++;
        if ({clk_o, tick_o, busy_o} !== 3'b111) $display("FAIL pre_reset_high: got %b want 111", {clk_o, tick_o, busy_o});
        else n_pass++;
        #2 rst_n_i = 1'b0;
        #1;
        n_total++;
        if ({clk_o, tick_o, busy_o} !== 3'b000) $display("FAIL async_reset: got %b want 000", {clk_o, tick_o, busy_o});
        else n_pass++;
        #4 rst_n_i = 1'b1;
        n_total++;
        if (cfg_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", cfg_ready_o);
        else n_pass++;
        step(1'b1, 1'b0, 8'd0, 1'b0, '0);
        clk_v[0] = clk_o; tick_v[0] = tick_o;
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, 1'b0, '0, 1'b0, '0);
            clk_v[k] = clk_o; tick_v[k] = tick_o;
        end
        n_total++;
        if (clk_v !== 32'h0000_3F80) $display("FAIL reset_def_half_clk: got %h want 00003f80", clk_v);
        else n_pass++;
        n_total++;
        if (tick_v !== 32'h0000_0080) $display("FAIL reset_def_half_tick: got %h want 00000080", tick_v);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_random();
        int n_bad = 0;
        logic [4:0] got, want;
        bit st, sp, cv;
        int bl, ch;
        rst_n_i = 1'b0;
        #3 rst_n_i = 1'b1;
        model_reset();
        for (int i = 0; i < 4000; i++) begin
            st = ($urandom_range(0, 7) == 0);
            sp = ($urandom_range(0, 15) == 0);
            cv = ($urandom_range(0, 3) == 0);
            bl = $urandom_range(0, 3);
            ch = $urandom_range(0, 6);
            model_edge(st, sp, bl, cv, ch);
            step(st, sp, BURST_W'(bl), cv, CNT_W'(ch));
            got  = {clk_o, tick_o, busy_o, done_o, cfg_ready_o};
            want = {m_lvl, m_tick, (m_mode != 0), m_done, !m_pend};
            n_total++;
            if (got !== want) begin
                n_bad++;
                if (n_bad <= 10)
                    $display("FAIL random cycle %0d {clk,tick,busy,done,rdy}: got %b want %b", i, got, want);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_burst();
        test_stop();
        test_cfg_running();
        test_half_zero();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
